// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module      : branch_history_table
//  Description : Direct-mapped, partially tagged branch history table with a
//                2-bit saturating direction counter per entry. Fetch lookups
//                are purely combinational; resolved-branch updates from
//                execute are written on the rising clock edge and become
//                visible to lookups from the following cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1       single clock, rising edge
//    rstn           in   1       asynchronous active-low reset
//    PC             in   WORD    fetch PC being looked up
//    predict        out  1       taken prediction for PC
//    hit            out  1       PC matches a valid entry
//    upd_valid      in   1       resolved-branch update this cycle
//    upd_PC         in   WORD    PC of the resolved branch
//    upd_taken      in   1       actual branch direction
//    upd_mispredict in   1       front-end prediction was wrong
//    flush_all      in   1       synchronous invalidate of every entry
//    upd_cnt        out  32      saturating count of accepted updates
//    mis_cnt        out  32      saturating count of mispredicted updates
// ============================================================================
`ifndef WORD
`define WORD 32
`endif

module branch_history_table #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 6
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [`WORD-1:0]   PC,
  output logic               predict,
  output logic               hit,
  input  logic               upd_valid,
  input  logic [`WORD-1:0]   upd_PC,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  input  logic               flush_all,
  output logic [31:0]        upd_cnt,
  output logic [31:0]        mis_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  // Lowest and highest PC bit that participates in index/tag.
  localparam int FLD_LO  = 2;
  localparam int FLD_HI  = IDX_W + TAG_W + 1;

  localparam logic [1:0] c_ctr_reset = 2'b01;  // weakly not-taken
  localparam logic [1:0] c_ctr_alloc = 2'b10;  // weakly taken
  localparam logic [31:0] c_cnt_max  = 32'hFFFF_FFFF;

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;

  assign w_lk_idx = PC[IDX_W+1:FLD_LO];
  assign w_lk_tag = PC[FLD_HI:IDX_W+2];
  assign w_up_idx = upd_PC[IDX_W+1:FLD_LO];
  assign w_up_tag = upd_PC[FLD_HI:IDX_W+2];

  // Byte-offset and upper PC bits carry no information for this table.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{PC[`WORD-1:FLD_HI+1], PC[1:0],
                              upd_PC[`WORD-1:FLD_HI+1], upd_PC[1:0]};

  // --------------------------------------------------------------------------
  // Read-side views of the per-entry state
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] w_valid;
  logic [TAG_W-1:0]   w_tag [ENTRIES];
  logic [1:0]         w_ctr [ENTRIES];

  // --------------------------------------------------------------------------
  // Fetch lookup (zero latency, reads pre-update state: no write bypass)
  // --------------------------------------------------------------------------
  logic w_lk_hit;

  assign w_lk_hit = w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);
  assign hit      = w_lk_hit;
  assign predict  = w_lk_hit & w_ctr[w_lk_idx][1];

  // --------------------------------------------------------------------------
  // Update decode, shared by all entries
  // --------------------------------------------------------------------------
  logic       w_up_hit;
  logic [1:0] w_up_ctr;
  logic [1:0] w_up_ctr_nxt;

  assign w_up_hit = w_valid[w_up_idx] && (w_tag[w_up_idx] == w_up_tag);
  assign w_up_ctr = w_ctr[w_up_idx];

  always_comb begin
    w_up_ctr_nxt = w_up_ctr;
    if (upd_taken) begin
      if (w_up_ctr != 2'b11) w_up_ctr_nxt = w_up_ctr + 2'd1;
    end else begin
      if (w_up_ctr != 2'b00) w_up_ctr_nxt = w_up_ctr - 2'd1;
    end
  end

  // A hit trains the counter; a taken miss (re)allocates, evicting any alias;
  // a not-taken miss is not worth an entry and leaves the table alone.
  logic w_do_train;
  logic w_do_alloc;

  assign w_do_train = upd_valid &  w_up_hit;
  assign w_do_alloc = upd_valid & ~w_up_hit & upd_taken;

  // --------------------------------------------------------------------------
  // Per-entry storage
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic             r_vld;
    logic [TAG_W-1:0] r_tg;
    logic [1:0]       r_ct;
    logic             w_sel;

    assign w_sel = (w_up_idx == IDX_W'(gi));

    // Flush wins over a same-cycle update; the whole entry is written in one
    // edge so an asynchronous reset can never leave it half-updated.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_vld <= 1'b0;
        r_tg  <= '0;
        r_ct  <= c_ctr_reset;
      end else if (flush_all) begin
        r_vld <= 1'b0;
      end else if (w_sel && w_do_train) begin
        r_ct  <= w_up_ctr_nxt;
      end else if (w_sel && w_do_alloc) begin
        r_vld <= 1'b1;
        r_tg  <= w_up_tag;
        r_ct  <= c_ctr_alloc;
      end
    end

    assign w_valid[gi] = r_vld;
    assign w_tag[gi]   = r_tg;
    assign w_ctr[gi]   = r_ct;
  end

  // --------------------------------------------------------------------------
  // Statistics: counted on every update, even one dropped by flush_all
  // --------------------------------------------------------------------------
  logic [31:0] r_upd_cnt;
  logic [31:0] r_mis_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_upd_cnt <= '0;
      r_mis_cnt <= '0;
    end else if (upd_valid) begin
      if (r_upd_cnt != c_cnt_max) r_upd_cnt <= r_upd_cnt + 32'd1;
      if (upd_mispredict && (r_mis_cnt != c_cnt_max))
        r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign upd_cnt = r_upd_cnt;
  assign mis_cnt = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_history_table
//  Description : Directed and random stimulus for branch_history_table,
//                checked against a table model built from plain arrays.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef WORD
`define WORD 32
`endif

module tb_branch_history_table;

  localparam int IDX_W = 6;
  localparam int TAG_W = 6;
  localparam int N     = 64;

  logic              clk = 1'b0;
  logic              rstn;
  logic [`WORD-1:0]  PC;
  logic              predict;
  logic              hit;
  logic              upd_valid;
  logic [`WORD-1:0]  upd_PC;
  logic              upd_taken;
  logic              upd_mispredict;
  logic              flush_all;
  logic [31:0]       upd_cnt;
  logic [31:0]       mis_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model
  bit              m_valid [N];
  int              m_tag   [N];
  int              m_ctr   [N];
  longint unsigned m_upd;
  longint unsigned m_mis;

  branch_history_table #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .PC             (PC),
    .predict        (predict),
    .hit            (hit),
    .upd_valid      (upd_valid),
    .upd_PC         (upd_PC),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .flush_all      (flush_all),
    .upd_cnt        (upd_cnt),
    .mis_cnt        (mis_cnt)
  );

  always #5 clk = ~clk;

  function automatic int f_idx(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int f_tag(input logic [31:0] pc);
    return int'((pc / (4 * N)) % (1 << TAG_W));
  endfunction

  function automatic bit f_hit(input logic [31:0] pc);
    return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
  endfunction

  function automatic bit f_pred(input logic [31:0] pc);
    return f_hit(pc) && (m_ctr[f_idx(pc)] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
    end
    m_upd = 0;
    m_mis = 0;
  endtask

  task automatic m_apply(input bit uv, input logic [31:0] upc, input bit ut,
                         input bit um, input bit fl);
    int i;
    i = f_idx(upc);
    if (fl) begin
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      if (f_hit(upc)) begin
        m_ctr[i] = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = f_tag(upc);
        m_ctr[i]   = 2;
      end
    end
    if (uv) begin
      if (m_upd < 64'hFFFF_FFFF) m_upd++;
      if (um && m_mis < 64'hFFFF_FFFF) m_mis++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check lookup against pre-edge model state,
  // advance the model at the edge, then check the statistics.
  task automatic step(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                      input bit ut, input bit um, input bit fl, input string tag);
    PC = pc; upd_valid = uv; upd_PC = upc; upd_taken = ut;
    upd_mispredict = um; flush_all = fl;
    #1;
    chk({tag, ".hit"}, 64'(hit), 64'(f_hit(pc)));
    chk({tag, ".predict"}, 64'(predict), 64'(f_pred(pc)));
    @(posedge clk);
    m_apply(uv, upc, ut, um, fl);
    @(negedge clk);
    chk({tag, ".upd_cnt"}, 64'(upd_cnt), m_upd);
    chk({tag, ".mis_cnt"}, 64'(mis_cnt), m_mis);
  endtask

  task automatic look(input logic [31:0] pc, input string tag);
    step(pc, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, tag);
  endtask

  task automatic upd(input logic [31:0] upc, input bit ut, input bit um,
                     input string tag);
    step(32'h0, 1'b1, upc, ut, um, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] a, b;
    bit uv, ut, um, fl;

    // ---- Reset with a live update on the inputs: must be ignored
    rstn = 1'b0; PC = 32'h1C00_0000; upd_valid = 1'b1; upd_PC = 32'h1C00_0000;
    upd_taken = 1'b1; upd_mispredict = 1'b1; flush_all = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.hit", 64'(hit), 64'd0);
    chk("rst.predict", 64'(predict), 64'd0);
    chk("rst.upd_cnt", 64'(upd_cnt), 64'd0);
    chk("rst.mis_cnt", 64'(mis_cnt), 64'd0);
    rstn = 1'b1;
    // First cycle after release, lookup of the reset-time update target
    look(32'h1C00_0000, "post_rst");

    // ---- Taken allocate, then two not-taken trains
    upd(32'h1C00_0010, 1'b1, 1'b0, "alloc");
    look(32'h1C00_0010, "alloc_lk");
    chk("alloc_lk.hit_const", 64'(f_hit(32'h1C00_0010)), 64'd1);
    upd(32'h1C00_0010, 1'b0, 1'b1, "nt1");
    upd(32'h1C00_0010, 1'b0, 1'b0, "nt2");
    look(32'h1C00_0010, "nt_lk");
    upd(32'h1C00_0010, 1'b0, 1'b0, "nt_sat");
    look(32'h1C00_0010, "nt_sat_lk");
    repeat (4) upd(32'h1C00_0010, 1'b1, 1'b0, "t_sat");
    look(32'h1C00_0010, "t_sat_lk");

    // ---- Alias: same index, different tag
    look(32'h1C00_0410, "alias_lk");
    upd(32'h1C00_0420, 1'b0, 1'b0, "nt_miss");
    look(32'h1C00_0420, "nt_miss_lk");
    upd(32'h1C00_0410, 1'b1, 1'b0, "alias_alloc");
    look(32'h1C00_0410, "alias_hit");
    look(32'h1C00_0010, "orig_miss");

    // ---- Update and lookup of the same PC in one cycle
    step(32'h1C00_0410, 1'b1, 32'h1C00_0410, 1'b0, 1'b1, 1'b0, "same_cyc");
    look(32'h1C00_0410, "same_next");

    // ---- Flush together with a taken update
    upd(32'h1C00_0020, 1'b1, 1'b0, "pre_flush");
    step(32'h1C00_0020, 1'b1, 32'h1C00_0030, 1'b1, 1'b1, 1'b1, "flush");
    look(32'h1C00_0020, "flush_a");
    look(32'h1C00_0030, "flush_b");
    look(32'h1C00_0410, "flush_c");

    // ---- Random traffic over a small PC pool to force hits and aliases
    for (int n = 0; n < 400; n++) begin
      a  = 32'h1C00_0000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
      b  = 32'h1C00_0000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
      uv = ($urandom_range(0, 1) == 1);
      ut = ($urandom_range(0, 2) != 0);
      um = ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 39) == 0);
      step(a, uv, b, ut, um, fl, "rnd");
    end

    // ---- Reset asserted mid-cycle while an allocating update is pending
    PC = 32'h1C00_00F0; upd_valid = 1'b1; upd_PC = 32'h1C00_00F0;
    upd_taken = 1'b1; upd_mispredict = 1'b1; flush_all = 1'b0;
    #2 rstn = 1'b0;
    m_reset();
    #1;
    chk("midrst.hit", 64'(hit), 64'd0);
    chk("midrst.upd_cnt", 64'(upd_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    look(32'h1C00_00F0, "midrst_lk");
    upd(32'h1C00_00F0, 1'b0, 1'b0, "midrst_nt");
    look(32'h1C00_00F0, "midrst_lk2");

    // ---- Statistics saturation
    force dut.r_upd_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_upd_cnt;
    m_upd = 64'hFFFF_FFFE;
    upd_valid = 1'b0;
    #1;
    chk("preload.upd_cnt", 64'(upd_cnt), m_upd);
    @(negedge clk);
    repeat (3) upd(32'h1C00_0044, 1'b1, 1'b1, "sat");
    chk("sat.upd_final", 64'(upd_cnt), 64'hFFFF_FFFF);
    chk("sat.mis_final", 64'(mis_cnt), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
